// File: rtl/pipe_field_pkg.sv
// Shared constants, coordinate type and LFSR helpers for the pipe_field obstacle engine.
package pipe_field_pkg;

  localparam int SCREEN_W = 640;

  localparam int LFSR_W = 16;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  localparam int DEF_NUM_PIPES   = 3;
  localparam int DEF_XW          = 12;
  localparam int DEF_PIPE_HALF_W = 24;
  localparam int DEF_GAP_HALF    = 75;
  localparam int DEF_SPACING     = 240;
  localparam int DEF_GAP_MIN     = 112;
  localparam int DEF_SCORE_W     = 10;

  typedef logic [DEF_XW-1:0] coord_t;

  // Fibonacci step for x^16 + x^14 + x^13 + x^11 + 1, shifting towards the MSB.
  function automatic logic [LFSR_W-1:0] lfsrNext(input logic [LFSR_W-1:0] v);
    return {v[LFSR_W-2:0], ^(v & LFSR_TAPS)};
  endfunction

  function automatic logic [7:0] gapByte(input logic [LFSR_W-1:0] v, input int idx);
    return 8'({v, v} >> (5 * idx));
  endfunction

endpackage

// File: rtl/pipe_field_if.sv
// Game-control side bundle of the pipe_field engine: controls in, pipe geometry and score out.
interface pipe_field_if #(
  parameter int NUM_PIPES = 3,
  parameter int XW        = 12,
  parameter int SCORE_W   = 10
);

  logic                    SoftReset;
  logic                    gameOn;
  logic                    frame_tick;
  logic [2:0]              speed;
  logic [7:0]              seed;
  logic [XW-1:0]           bird_x;
  logic [NUM_PIPES*XW-1:0] pipe_x;
  logic [NUM_PIPES*XW-1:0] gap_y;
  logic [XW-1:0]           width;
  logic [XW-1:0]           gapSize;
  logic [SCORE_W-1:0]      score;
  logic                    pass_pulse;

  modport master (
    output SoftReset, gameOn, frame_tick, speed, seed, bird_x,
    input  pipe_x, gap_y, width, gapSize, score, pass_pulse
  );

  modport slave (
    input  SoftReset, gameOn, frame_tick, speed, seed, bird_x,
    output pipe_x, gap_y, width, gapSize, score, pass_pulse
  );

endinterface

// File: rtl/lfsr16.sv
// Free-running 16-bit LFSR; shows the seed while in reset, then steps every clock unless reloaded.
module lfsr16
  import pipe_field_pkg::*;
(
  input  logic        clk,
  input  logic        Reset,
  input  logic        load,
  input  logic [15:0] seed16,
  output logic [15:0] value
);

  logic [15:0] state;
  logic        loaded;

  // Until the first edge after reset the register is not yet seeded, so the seed is passed through.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state  <= '0;
      loaded <= 1'b0;
    end else if (load) begin
      state  <= seed16;
      loaded <= 1'b1;
    end else begin
      state  <= lfsrNext(value);
      loaded <= 1'b1;
    end
  end

  assign value = loaded ? state : seed16;

endmodule

// File: rtl/pipe_field.sv
// Multi-pipe scrolling obstacle field with random gaps and bird-pass scoring.
// Define PIPE_FIELD_SPEEDUP_EN to add +1 step per 16 points (max +3, step capped at 7).
module pipe_field
  import pipe_field_pkg::*;
#(
  parameter int NUM_PIPES   = DEF_NUM_PIPES,
  parameter int XW          = DEF_XW,
  parameter int PIPE_HALF_W = DEF_PIPE_HALF_W,
  parameter int GAP_HALF    = DEF_GAP_HALF,
  parameter int SPACING     = DEF_SPACING,
  parameter int GAP_MIN     = DEF_GAP_MIN,
  parameter int SCORE_W     = DEF_SCORE_W
) (
  input logic         clk,
  input logic         Reset,
  pipe_field_if.slave bus
);

  localparam logic [XW:0]   HALF_W = (XW+1)'(PIPE_HALF_W);
  localparam logic [XW-1:0] WRAP   = XW'(NUM_PIPES * SPACING);

  logic [15:0]          seed16;
  logic [15:0]          lfsrValue;
  logic                 doMove;
  logic                 seeded;
  logic [2:0]           baseStep;
  logic [2:0]           step;
  logic [NUM_PIPES-1:0] passEv;
  logic [XW-1:0]        xArr   [NUM_PIPES];
  logic [XW-1:0]        gapArr [NUM_PIPES];
  logic [2:0]           passCount;
  logic [SCORE_W:0]     scoreSum;
  logic [SCORE_W-1:0]   scoreReg;
  logic                 pulseReg;

  assign seed16 = {bus.seed, ~bus.seed};
  assign doMove = bus.frame_tick && bus.gameOn && !bus.SoftReset;

  lfsr16 uLfsr (
    .clk    (clk),
    .Reset  (Reset),
    .load   (bus.SoftReset),
    .seed16 (seed16),
    .value  (lfsrValue)
  );

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) seeded <= 1'b0;
    else        seeded <= 1'b1;
  end

  assign baseStep = (bus.speed == 3'd0) ? 3'd1 : bus.speed;

`ifdef PIPE_FIELD_SPEEDUP_EN
  logic [SCORE_W-1:0] level;
  logic [1:0]         bonus;
  logic [3:0]         boosted;

  always_comb begin
    level   = scoreReg >> 4;
    bonus   = (level > SCORE_W'(3)) ? 2'd3 : level[1:0];
    boosted = {1'b0, baseStep} + {2'b00, bonus};
    step    = (boosted > 4'd7) ? 3'd7 : boosted[2:0];
  end
`else
  assign step = baseStep;
`endif

  for (genvar i = 0; i < NUM_PIPES; i++) begin : gPipe
    localparam logic [XW-1:0] X_INIT = XW'(SCREEN_W + PIPE_HALF_W + i * SPACING);

    logic [XW-1:0] xReg;
    logic [XW-1:0] gapReg;
    logic [XW-1:0] xDec;
    logic [XW-1:0] xNext;
    logic [XW-1:0] gapInit;
    logic [XW-1:0] gapNew;
    logic [XW-1:0] gapCur;
    logic          respawn;

    assign respawn = ({1'b0, xReg} < (HALF_W + (XW+1)'(step)));
    assign xDec    = xReg - XW'(step);
    assign xNext   = respawn ? (xDec + WRAP) : xDec;
    assign gapInit = XW'(GAP_MIN) + XW'(gapByte(seed16, i));
    assign gapNew  = XW'(GAP_MIN) + XW'(gapByte(lfsrValue, i));
    // The gap register only holds real data from the first edge after reset.
    assign gapCur  = seeded ? gapReg : gapInit;

    assign passEv[i] = doMove && !respawn &&
                       (({1'b0, xReg}  + HALF_W) >= {1'b0, bus.bird_x}) &&
                       (({1'b0, xNext} + HALF_W) <  {1'b0, bus.bird_x});

    always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
        xReg   <= X_INIT;
        gapReg <= '0;
      end else if (bus.SoftReset) begin
        xReg   <= X_INIT;
        gapReg <= gapInit;
      end else if (doMove) begin
        xReg   <= xNext;
        gapReg <= respawn ? gapNew : gapCur;
      end else begin
        gapReg <= gapCur;
      end
    end

    assign xArr[i]   = xReg;
    assign gapArr[i] = gapCur;
  end

  always_comb begin
    bus.pipe_x = '0;
    bus.gap_y  = '0;
    passCount  = '0;
    for (int k = 0; k < NUM_PIPES; k++) begin
      bus.pipe_x[k*XW +: XW] = xArr[k];
      bus.gap_y[k*XW +: XW]  = gapArr[k];
      passCount              = passCount + 3'(passEv[k]);
    end
  end

  // Simultaneous passes are summed; the carry bit flags saturation.
  assign scoreSum = {1'b0, scoreReg} + (SCORE_W+1)'(passCount);

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      scoreReg <= '0;
      pulseReg <= 1'b0;
    end else if (bus.SoftReset) begin
      scoreReg <= '0;
      pulseReg <= 1'b0;
    end else begin
      if (doMove) scoreReg <= scoreSum[SCORE_W] ? '1 : scoreSum[SCORE_W-1:0];
      pulseReg <= |passEv;
    end
  end

  assign bus.score      = scoreReg;
  assign bus.pass_pulse = pulseReg;
  assign bus.width      = XW'(PIPE_HALF_W);
  assign bus.gapSize    = XW'(GAP_HALF);

endmodule

// File: tb/tb_pipe_field.sv
// Scoreboard bench for pipe_field: stimulus queues expected snapshots, monitors pop and compare them.
module tb_pipe_field;

  localparam int NP = 3;
  localparam int XW = 12;
  localparam int PW = NP * XW;
  localparam int SW = 10;

  typedef struct {
    string         name;
    logic [PW-1:0] px;
    logic [PW-1:0] gy;
    logic [PW-1:0] gyMask;
    int            score;
    bit            pulse;
    bit            rangeChk;
  } exp_t;

  logic clk   = 1'b0;
  logic Reset = 1'b0;
  always #5 clk = ~clk;

  pipe_field_if #(.NUM_PIPES(NP), .XW(XW), .SCORE_W(SW)) bus ();

  pipe_field dut (
    .clk   (clk),
    .Reset (Reset),
    .bus   (bus)
  );

  exp_t        expQ[$];
  int          errors = 0;
  int          checks = 0;
  bit          expectTick = 1'b0;
  bit          expectSeen = 1'b0;
  event        probe;
  logic [15:0] mLfsr;
  logic [11:0] gap0Resp;

  function automatic logic [PW-1:0] pack3(input int a, input int b, input int c);
    return {12'(c), 12'(b), 12'(a)};
  endfunction

  function automatic logic [7:0] modelByte(input logic [15:0] m, input int idx);
    logic [31:0] d;
    d = {m, m};
    d = d >> (5 * idx);
    return d[7:0];
  endfunction

  function automatic exp_t mk(input string name, input logic [PW-1:0] px, input logic [PW-1:0] gy,
                              input int score, input bit pulse);
    exp_t e;
    e.name = name; e.px = px; e.gy = gy; e.gyMask = '1;
    e.score = score; e.pulse = pulse; e.rangeChk = 1'b0;
    return e;
  endfunction

  // Reference LFSR built from the polynomial, seeded and stepped like the game expects.
  always @(posedge clk or negedge Reset) begin
    if (!Reset)             mLfsr <= {bus.seed, ~bus.seed};
    else if (bus.SoftReset) mLfsr <= {bus.seed, ~bus.seed};
    else                    mLfsr <= {mLfsr[14:0], mLfsr[15] ^ mLfsr[13] ^ mLfsr[12] ^ mLfsr[10]};
  end

  always @(posedge clk or negedge Reset) begin
    if (!Reset) expectSeen <= 1'b0;
    else        expectSeen <= expectTick && bus.frame_tick;
  end

  task automatic checkField(input string name, input string field, input logic [PW-1:0] act,
                            input logic [PW-1:0] exp, input logic [PW-1:0] mask);
    checks++;
    if ((act & mask) !== (exp & mask)) begin
      errors++;
      $display("[TB] FAIL %s %s: got %0h expected %0h", name, field, act & mask, exp & mask);
    end
  endtask

  task automatic checkOutput();
    exp_t        e;
    logic [11:0] g;
    if (expQ.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL unexpected_output: got a response with empty scoreboard, expected none");
      return;
    end
    e = expQ.pop_front();
    checkField(e.name, "pipe_x", bus.pipe_x, e.px, '1);
    if (e.gyMask != '0) checkField(e.name, "gap_y", bus.gap_y, e.gy, e.gyMask);
    checkField(e.name, "score", PW'(bus.score), PW'(e.score), '1);
    checkField(e.name, "pass_pulse", PW'(bus.pass_pulse), PW'(e.pulse), '1);
    checkField(e.name, "width", PW'(bus.width), PW'(24), '1);
    checkField(e.name, "gapSize", PW'(bus.gapSize), PW'(75), '1);
    if (e.rangeChk) begin
      g = bus.gap_y[11:0];
      checks++;
      if (g < 12'd112 || g > 12'd367) begin
        errors++;
        $display("[TB] FAIL %s gap_range: got %0d expected 112..367", e.name, g);
      end
    end
  endtask

  always @(negedge clk) if (expectSeen) checkOutput();

  initial forever begin
    @probe;
    checkOutput();
  end

  task automatic applyStimulus(input bit chk);
    bus.frame_tick = 1'b1;
    expectTick     = chk;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    expectTick     = 1'b0;
    @(negedge clk);
  endtask

  task automatic runTicks(input int n);
    repeat (n) applyStimulus(1'b0);
  endtask

  initial begin
    logic [PW-1:0] initX;
    logic [PW-1:0] gapsSeed0;
    logic [PW-1:0] gapsSeed5A;
    logic [PW-1:0] gapsResp;
    exp_t          e;

    initX      = pack3(664, 904, 1144);
    gapsSeed0  = pack3(367, 119, 304);
    gapsSeed5A = pack3(277, 325, 198);

    bus.SoftReset  = 1'b0;
    bus.gameOn     = 1'b0;
    bus.frame_tick = 1'b0;
    bus.speed      = 3'd2;
    bus.seed       = 8'h00;
    bus.bird_x     = '0;

    #12;
    expQ.push_back(mk("reset", initX, gapsSeed0, 0, 1'b0));
    -> probe;

    @(negedge clk);
    Reset      = 1'b1;
    bus.gameOn = 1'b1;
    @(negedge clk);

    expQ.push_back(mk("tick1", pack3(662, 902, 1142), gapsSeed0, 0, 1'b0));
    applyStimulus(1'b1);
    runTicks(8);
    expQ.push_back(mk("tick10", pack3(644, 884, 1124), gapsSeed0, 0, 1'b0));
    applyStimulus(1'b1);

    runTicks(309);
    expQ.push_back(mk("edge24", pack3(24, 264, 504), gapsSeed0, 0, 1'b0));
    applyStimulus(1'b1);

    gap0Resp = 12'd112 + 12'(modelByte(mLfsr, 0));
    gapsResp = pack3(int'(gap0Resp), 119, 304);
    e = mk("respawn", pack3(742, 262, 502), gapsResp, 0, 1'b0);
    e.rangeChk = 1'b1;
    expQ.push_back(e);
    applyStimulus(1'b1);

    bus.speed = 3'd1;
    applyStimulus(1'b0);
    bus.speed = 3'd2;
    runTicks(92);
    bus.bird_x = 12'd100;
    expQ.push_back(mk("pass", pack3(555, 75, 315), gapsResp, 1, 1'b1));
    applyStimulus(1'b1);
    #1;
    expQ.push_back(mk("pulse_drop", pack3(555, 75, 315), gapsResp, 1, 1'b0));
    -> probe;
    @(negedge clk);
    expQ.push_back(mk("no_repass", pack3(553, 73, 313), gapsResp, 1, 1'b0));
    applyStimulus(1'b1);

    bus.gameOn = 1'b0;
    runTicks(4);
    expQ.push_back(mk("hold", pack3(553, 73, 313), gapsResp, 1, 1'b0));
    applyStimulus(1'b1);

    bus.gameOn = 1'b1;
    bus.speed  = 3'd0;
    expQ.push_back(mk("speed0", pack3(552, 72, 312), gapsResp, 1, 1'b0));
    applyStimulus(1'b1);
    bus.speed = 3'd7;
    expQ.push_back(mk("speed7", pack3(545, 65, 305), gapsResp, 1, 1'b0));
    applyStimulus(1'b1);

    bus.seed      = 8'h5A;
    bus.SoftReset = 1'b1;
    expQ.push_back(mk("softreset", initX, gapsSeed5A, 0, 1'b0));
    applyStimulus(1'b1);
    bus.SoftReset = 1'b0;

    bus.speed = 3'd2;
    runTicks(3);
    @(posedge clk);
    #3;
    Reset = 1'b0;
    #1;
    expQ.push_back(mk("async_reset", initX, gapsSeed5A, 0, 1'b0));
    -> probe;
    @(negedge clk);
    Reset = 1'b1;

    repeat (3) @(negedge clk);
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending entries expected 0", expQ.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
